// File: rtl/mydesign_tb_pkg.sv
// Shared types and constants for the exhaustive sweep checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mydesign_tb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  localparam int OP_MUL      = 0;
  localparam int OP_ADD      = 1;
  localparam int LATENCY_MAX = 7;

  // Wide enough to count down LATENCY_MAX-1 drain cycles.
  localparam int DRAIN_W = 3;

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/mydesign_expect_pipe.sv
// Delay line carrying {valid, a, b, expected} alongside the operator under test.
// Latency: LATENCY cycles; LATENCY=0 is a combinational passthrough.
// Backpressure: none; shifts every cycle, synchronous clear drops all valids.
module mydesign_expect_pipe #(
  parameter int LATENCY = 1,
  parameter int W       = 12
) (
  input  logic         clk_ci,
  input  logic         clr_i,
  input  logic         in_vld_i,
  input  logic [W-1:0] in_dat_i,
  output logic         out_vld_o,
  output logic [W-1:0] out_dat_o
);

  // At least one stage exists so the storage is always well-formed.
  localparam int DEPTH = (LATENCY > 0) ? LATENCY : 1;

  logic         vld_q [DEPTH];
  logic         vld_d [DEPTH];
  logic [W-1:0] dat_q [DEPTH];
  logic [W-1:0] dat_d [DEPTH];

  // Next stage contents: new entry at stage 0, everything else moves up one.
  always_comb begin
    vld_d[0] = in_vld_i;
    dat_d[0] = in_dat_i;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i] = vld_q[i-1];
      dat_d[i] = dat_q[i-1];
    end
  end

  // Stage registers; clear wipes in-flight entries so nothing stale is compared.
  always_ff @(posedge clk_ci) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr_i) begin
        vld_q[i] <= 1'b0;
        dat_q[i] <= '0;
      end else begin
        vld_q[i] <= vld_d[i];
        dat_q[i] <= dat_d[i];
      end
    end
  end

  assign out_vld_o = (LATENCY == 0) ? in_vld_i : vld_q[DEPTH-1];
  assign out_dat_o = (LATENCY == 0) ? in_dat_i : dat_q[DEPTH-1];

endmodule

// File: rtl/mydesign_sweep_checker.sv
// Drives every (a, b) pair to the operator under test and checks its results.
// Latency: done pulses 2^(2*N_IN)+LATENCY+1 cycles after start is sampled.
// Backpressure: none; start is ignored until the sweep returns to IDLE.
module mydesign_sweep_checker
  import mydesign_tb_pkg::*;
#(
  parameter int N_IN    = 3,
  parameter int N_OUT   = 6,
  parameter int LATENCY = 1,
  parameter int OP      = OP_MUL
) (
  input  logic                clk_ci,
  input  logic                rst_ci,
  input  logic                start_i,
  output logic [N_IN-1:0]     operand_a_o,
  output logic [N_IN-1:0]     operand_b_o,
  input  logic [N_OUT-1:0]    result_i,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [2*N_IN:0]     err_count_o,
  output logic                fail_valid_o,
  output logic [N_IN-1:0]     fail_a_o,
  output logic [N_IN-1:0]     fail_b_o
);

  localparam int IDX_W  = 2 * N_IN;
  localparam int ERR_W  = 2 * N_IN + 1;
  localparam int GOLD_W = max_int(IDX_W, N_OUT);
  localparam int PAY_W  = 2 * N_IN + N_OUT;

  localparam logic [IDX_W-1:0]   IDX_LAST   = '1;
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'((LATENCY > 0) ? (LATENCY - 1) : 0);

  sweep_state_e         state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [N_IN-1:0]      op_a_q, op_a_d, op_b_q, op_b_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 pass_q, pass_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 fv_q, fv_d;
  logic [N_IN-1:0]      fa_q, fa_d, fb_q, fb_d;

  logic [IDX_W-1:0]     prod;
  logic [N_IN:0]        sum;
  logic [GOLD_W-1:0]    gold_wide;
  logic [N_OUT-1:0]     gold;

  logic                 cmp_vld;
  logic [PAY_W-1:0]     cmp_dat;
  logic [N_IN-1:0]      cmp_a, cmp_b;
  logic [N_OUT-1:0]     cmp_exp;
  logic                 mismatch;

  // Golden value for the operands currently on the bus, resized to N_OUT.
  always_comb begin
    prod      = IDX_W'(op_a_q) * IDX_W'(op_b_q);
    sum       = (N_IN+1)'(op_a_q) + (N_IN+1)'(op_b_q);
    gold_wide = (OP == OP_ADD) ? GOLD_W'(sum) : GOLD_W'(prod);
    gold      = gold_wide[N_OUT-1:0];
  end

  // Expected values travel alongside the operator's own pipeline.
  mydesign_expect_pipe #(
    .LATENCY (LATENCY),
    .W       (PAY_W)
  ) u_pipe (
    .clk_ci    (clk_ci),
    .clr_i     (rst_ci),
    .in_vld_i  (state_q == ST_DRIVE),
    .in_dat_i  ({op_a_q, op_b_q, gold}),
    .out_vld_o (cmp_vld),
    .out_dat_o (cmp_dat)
  );

  assign {cmp_a, cmp_b, cmp_exp} = cmp_dat;
  assign mismatch = cmp_vld && (result_i != cmp_exp);

  // Next-state: sweep sequencing, operand stepping, error bookkeeping.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    drain_d = drain_q;
    pass_d  = pass_q;
    err_d   = err_q;
    fv_d    = fv_q;
    fa_d    = fa_q;
    fb_d    = fb_q;

    // Compares are independent of state so in-flight vectors always land.
    if (mismatch) begin
      err_d = err_q + ERR_W'(1);
      if (!fv_q) begin
        fv_d = 1'b1;
        fa_d = cmp_a;
        fb_d = cmp_b;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = ST_DRIVE;
          idx_d   = '0;
          op_a_d  = '0;
          op_b_d  = '0;
          err_d   = '0;
          fv_d    = 1'b0;
          fa_d    = '0;
          fb_d    = '0;
          pass_d  = 1'b0;
        end
      end
      ST_DRIVE: begin
        if (idx_q == IDX_LAST) begin
          state_d = (LATENCY > 0) ? ST_DRAIN : ST_DONE;
          drain_d = DRAIN_INIT;
          op_a_d  = '0;
          op_b_d  = '0;
        end else begin
          idx_d  = idx_q + IDX_W'(1);
          op_a_d = idx_d[N_IN-1:0];
          op_b_d = idx_d[IDX_W-1:N_IN];
        end
      end
      ST_DRAIN: begin
        if (drain_q == '0) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - DRAIN_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Verdict lands together with the done pulse and includes the last compare.
    if (state_d == ST_DONE) begin
      pass_d = (err_d == '0);
    end

    busy_d = (state_d == ST_DRIVE) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // State and registered outputs; synchronous reset returns everything to zero.
  always_ff @(posedge clk_ci) begin
    if (rst_ci) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      drain_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      fv_q    <= 1'b0;
      fa_q    <= '0;
      fb_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      drain_q <= drain_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
    end
  end

  assign operand_a_o  = op_a_q;
  assign operand_b_o  = op_b_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign pass_o       = pass_q;
  assign err_count_o  = err_q;
  assign fail_valid_o = fv_q;
  assign fail_a_o     = fa_q;
  assign fail_b_o     = fb_q;

endmodule

// File: tb/tb_mydesign_sweep_checker.sv
// Bench for the sweep checker: three instances (mul L=1, add L=0, mul L=3) facing stub operators.
// Latency: stub delays 1, 0 and 3 (or a deliberately short 2).
// Backpressure: none.
module tb_mydesign_sweep_checker;

  typedef struct {
    int err;
    int fv;
    int fa;
    int fb;
    int pass;
    int done_cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic start;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   start_cyc = 0;
  bit   active = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Instance signals: m_ = multiplier L=1, a_ = adder L=0, t_ = multiplier L=3.
  logic [2:0] m_opa, m_opb, a_opa, a_opb, t_opa, t_opb;
  logic [5:0] m_res, a_res, t_res;
  logic       m_busy, m_done, m_pass, m_fv;
  logic       a_busy, a_done, a_pass, a_fv;
  logic       t_busy, t_done, t_pass, t_fv;
  logic [6:0] m_err, a_err, t_err;
  logic [2:0] m_fa, m_fb, a_fa, a_fb, t_fa, t_fb;

  // Stub configuration: mode 0 ideal, 1 stuck-at-0 bit, 2 plus one, 3 xor mask per pair.
  int         m_mode = 0, m_sb = 0, a_mode = 0, a_sb = 0, t_mode = 0, t_sb = 0;
  bit         t_short = 1'b0;
  logic [5:0] m_mask [64];
  logic [5:0] a_mask [64];
  logic [5:0] t_mask [64];

  exp_t m_q[$];
  exp_t a_q[$];
  exp_t t_q[$];

  mydesign_sweep_checker #(.N_IN(3), .N_OUT(6), .LATENCY(1), .OP(0)) u_mul (
    .clk_ci(clk), .rst_ci(rst), .start_i(start),
    .operand_a_o(m_opa), .operand_b_o(m_opb), .result_i(m_res),
    .busy_o(m_busy), .done_o(m_done), .pass_o(m_pass), .err_count_o(m_err),
    .fail_valid_o(m_fv), .fail_a_o(m_fa), .fail_b_o(m_fb));

  mydesign_sweep_checker #(.N_IN(3), .N_OUT(6), .LATENCY(0), .OP(1)) u_add (
    .clk_ci(clk), .rst_ci(rst), .start_i(start),
    .operand_a_o(a_opa), .operand_b_o(a_opb), .result_i(a_res),
    .busy_o(a_busy), .done_o(a_done), .pass_o(a_pass), .err_count_o(a_err),
    .fail_valid_o(a_fv), .fail_a_o(a_fa), .fail_b_o(a_fb));

  mydesign_sweep_checker #(.N_IN(3), .N_OUT(6), .LATENCY(3), .OP(0)) u_l3 (
    .clk_ci(clk), .rst_ci(rst), .start_i(start),
    .operand_a_o(t_opa), .operand_b_o(t_opb), .result_i(t_res),
    .busy_o(t_busy), .done_o(t_done), .pass_o(t_pass), .err_count_o(t_err),
    .fail_valid_o(t_fv), .fail_a_o(t_fa), .fail_b_o(t_fb));

  function automatic logic [5:0] golden(input int op, input int a, input int b);
    int v;
    v = (op == 0) ? a * b : a + b;
    return v[5:0];
  endfunction

  function automatic logic [5:0] stub_val(input int op, input int mode, input int sb,
                                          input logic [5:0] mask, input int a, input int b);
    logic [5:0] g;
    g = golden(op, a, b);
    case (mode)
      1: g[sb] = 1'b0;
      2: g = g + 6'd1;
      3: g = g ^ mask;
      default: ;
    endcase
    return g;
  endfunction

  // Stub operators: combinational value then a history line for the registered ones.
  logic [5:0] m_f, a_f, t_f;
  logic [5:0] m_h [4];
  logic [5:0] t_h [4];
  always_comb m_f = stub_val(0, m_mode, m_sb, m_mask[{m_opb, m_opa}], int'(m_opa), int'(m_opb));
  always_comb a_f = stub_val(1, a_mode, a_sb, a_mask[{a_opb, a_opa}], int'(a_opa), int'(a_opb));
  always_comb t_f = stub_val(0, t_mode, t_sb, t_mask[{t_opb, t_opa}], int'(t_opa), int'(t_opb));
  always @(posedge clk) begin
    m_h[0] <= m_f;
    for (int i = 1; i < 4; i++) m_h[i] <= m_h[i-1];
  end
  always @(posedge clk) begin
    t_h[0] <= t_f;
    for (int i = 1; i < 4; i++) t_h[i] <= t_h[i-1];
  end
  assign m_res = m_h[0];
  assign a_res = a_f;
  assign t_res = t_short ? t_h[1] : t_h[2];

  function automatic logic [5:0] stub_of(input int inst, input int idx);
    case (inst)
      0:       return stub_val(0, m_mode, m_sb, m_mask[idx], idx % 8, idx / 8);
      1:       return stub_val(1, a_mode, a_sb, a_mask[idx], idx % 8, idx / 8);
      default: return stub_val(0, t_mode, t_sb, t_mask[idx], idx % 8, idx / 8);
    endcase
  endfunction

  // Reference: for each vector, what the operator hands back when that vector is checked.
  function automatic exp_t model(input int inst, input int op, input int lat, input bit shift);
    exp_t e;
    int   src;
    e.err = 0; e.fv = 0; e.fa = 0; e.fb = 0;
    for (int k = 0; k < 64; k++) begin
      // A short operator delivers the next vector's answer; after the last one the bus is 0/0.
      src = shift ? ((k < 63) ? k + 1 : 0) : k;
      if (stub_of(inst, src) != golden(op, k % 8, k / 8)) begin
        e.err++;
        if (e.fv == 0) begin
          e.fv = 1; e.fa = k % 8; e.fb = k / 8;
        end
      end
    end
    e.pass     = (e.err == 0) ? 1 : 0;
    e.done_cyc = start_cyc + 65 + lat;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic chk_idle(input string nm, input logic busy, input logic done, input logic pass,
                          input logic [6:0] err, input logic fv, input logic [2:0] fa,
                          input logic [2:0] fb, input logic [2:0] opa, input logic [2:0] opb);
    chk({nm, "_busy0"}, busy, 0);
    chk({nm, "_done0"}, done, 0);
    chk({nm, "_pass0"}, pass, 0);
    chk({nm, "_err0"}, err, 0);
    chk({nm, "_fv0"}, fv, 0);
    chk({nm, "_fa0"}, fa, 0);
    chk({nm, "_fb0"}, fb, 0);
    chk({nm, "_opa0"}, opa, 0);
    chk({nm, "_opb0"}, opb, 0);
  endtask

  task automatic chk_cycle(input string nm, input logic [2:0] opa, input logic [2:0] opb,
                           input logic busy, input int d, input int lat);
    bit drv;
    drv = (d >= 1) && (d <= 64);
    chk({nm, "_opa"}, opa, drv ? (d - 1) % 8 : 0);
    chk({nm, "_opb"}, opb, drv ? (d - 1) / 8 : 0);
    chk({nm, "_busy"}, busy, ((d >= 1) && (d <= 64 + lat)) ? 1 : 0);
  endtask

  task automatic sb_cmp(input string nm, input exp_t e, input logic [6:0] err, input logic fv,
                        input logic [2:0] fa, input logic [2:0] fb, input logic pass);
    chk({nm, "_done_cycle"}, cyc - start_cyc, e.done_cyc - start_cyc);
    chk({nm, "_err_count"}, err, e.err);
    chk({nm, "_fail_valid"}, fv, e.fv);
    chk({nm, "_fail_a"}, fa, e.fa);
    chk({nm, "_fail_b"}, fb, e.fb);
    chk({nm, "_pass"}, pass, e.pass);
  endtask

  task automatic unexpected(input string nm);
    checks++;
    errors++;
    $display("FAIL %s_done actual=1 required=0 (no sweep outstanding, cycle %0d)", nm, cyc);
  endtask

  // Monitor: per-cycle bus/busy checks and scoreboard pops on every done pulse.
  always @(negedge clk) begin
    int   d;
    exp_t e;
    if (!rst) begin
      d = active ? (cyc - start_cyc) : -1;
      chk_cycle("mul", m_opa, m_opb, m_busy, d, 1);
      chk_cycle("add", a_opa, a_opb, a_busy, d, 0);
      chk_cycle("l3", t_opa, t_opb, t_busy, d, 3);
      if (m_done) begin
        if (m_q.size() == 0) unexpected("mul");
        else begin e = m_q.pop_front(); sb_cmp("mul", e, m_err, m_fv, m_fa, m_fb, m_pass); end
      end
      if (a_done) begin
        if (a_q.size() == 0) unexpected("add");
        else begin e = a_q.pop_front(); sb_cmp("add", e, a_err, a_fv, a_fa, a_fb, a_pass); end
      end
      if (t_done) begin
        if (t_q.size() == 0) unexpected("l3");
        else begin e = t_q.pop_front(); sb_cmp("l3", e, t_err, t_fv, t_fa, t_fb, t_pass); end
      end
    end
  end

  // Called just after a rising edge: raises start for the current cycle (cycle 0).
  task automatic issue_start(input int hold);
    start     = 1'b1;
    start_cyc = cyc;
    active    = 1'b1;
    m_q.push_back(model(0, 0, 1, 1'b0));
    a_q.push_back(model(1, 1, 0, 1'b0));
    t_q.push_back(model(2, 0, 3, t_short));
    @(posedge clk); #1;
    chk("mul_clear_err", m_err, 0);   chk("mul_clear_fv", m_fv, 0);   chk("mul_clear_pass", m_pass, 0);
    chk("add_clear_err", a_err, 0);   chk("add_clear_fv", a_fv, 0);   chk("add_clear_pass", a_pass, 0);
    chk("l3_clear_err", t_err, 0);    chk("l3_clear_fv", t_fv, 0);    chk("l3_clear_pass", t_pass, 0);
    chk("mul_clear_fa", m_fa, 0);     chk("mul_clear_fb", m_fb, 0);
    repeat (hold) begin @(posedge clk); #1; end
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while ((m_q.size() + a_q.size() + t_q.size()) != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL sweep_timeout actual=%0d required=0 outstanding sweeps", m_q.size() + a_q.size() + t_q.size());
      m_q.delete(); a_q.delete(); t_q.delete();
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic rand_cfg();
    m_mode = $urandom_range(0, 3); m_sb = $urandom_range(0, 5);
    a_mode = $urandom_range(0, 3); a_sb = $urandom_range(0, 5);
    t_mode = $urandom_range(0, 3); t_sb = $urandom_range(0, 5);
    t_short = 1'($urandom_range(0, 1));
    for (int k = 0; k < 64; k++) begin
      m_mask[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      a_mask[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      t_mask[k] = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    for (int k = 0; k < 64; k++) begin
      m_mask[k] = 6'd0; a_mask[k] = 6'd0; t_mask[k] = 6'd0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_idle("mul_rst", m_busy, m_done, m_pass, m_err, m_fv, m_fa, m_fb, m_opa, m_opb);
    chk_idle("add_rst", a_busy, a_done, a_pass, a_err, a_fv, a_fa, a_fb, a_opa, a_opb);
    chk_idle("l3_rst", t_busy, t_done, t_pass, t_err, t_fv, t_fa, t_fb, t_opa, t_opb);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ideal operators everywhere.
    issue_start(0);
    wait_done();

    // Stuck bit 5 on the multiplier, off-by-one adder, L=3 checker facing a delay-2 operator.
    m_mode = 1; m_sb = 5; a_mode = 2; t_short = 1'b1;
    issue_start(0);
    wait_done();
    chk("mul_stuck5_err", m_err, 6);
    chk("mul_stuck5_fa", m_fa, 7);
    chk("mul_stuck5_fb", m_fb, 5);
    chk("mul_stuck5_pass", m_pass, 0);
    chk("add_plus1_err", a_err, 64);
    chk("add_plus1_fv", a_fv, 1);
    chk("add_plus1_fa", a_fa, 0);
    chk("add_plus1_fb", a_fb, 0);

    // Start held high across the sweep: exactly one sweep, counters cleared from the last one.
    m_mode = 0; a_mode = 0; t_short = 1'b0;
    issue_start(62);
    wait_done();
    repeat (10) begin @(posedge clk); #1; end
    chk("held_start_busy", m_busy | a_busy | t_busy, 0);
    chk("held_start_pass", {m_pass, a_pass, t_pass}, 3'b111);

    // Reset in the middle of DRIVE with faulty operators, then a clean restart.
    m_mode = 2; a_mode = 2; t_short = 1'b1;
    issue_start(0);
    repeat (29) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    active = 1'b0;
    m_q.delete(); a_q.delete(); t_q.delete();
    rst = 1'b0;
    chk_idle("mul_midrst", m_busy, m_done, m_pass, m_err, m_fv, m_fa, m_fb, m_opa, m_opb);
    chk_idle("add_midrst", a_busy, a_done, a_pass, a_err, a_fv, a_fa, a_fb, a_opa, a_opb);
    chk_idle("l3_midrst", t_busy, t_done, t_pass, t_err, t_fv, t_fa, t_fb, t_opa, t_opb);
    @(posedge clk); #1;
    rand_cfg();
    issue_start(0);
    wait_done();

    // Randomized operator faults and start hold lengths.
    repeat (6) begin
      rand_cfg();
      issue_start(($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : 0);
      wait_done();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
